// File: rtl/mxu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mxu_pkg
//  Purpose  : Shared types and phase-length helpers for the MXU scheduler.
//             Phase lengths derive from the systolic array dimension SIZE.
//  Revision : 1.0  initial release
// ============================================================================
package mxu_pkg;

    // Sequencer states, one per job phase plus the idle arbitration state.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MULT = 3'd2,
        ST_ACC  = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    localparam int DEF_SIZE = 16;

    // Operand load takes one cycle per array row.
    function automatic int load_cycles(input int size);
        return size;
    endfunction

    // Systolic fill + compute + drain across the diagonal.
    function automatic int mult_cycles(input int size);
        return 3 * size - 2;
    endfunction

    // Wide enough to index every cycle of the longest phase.
    function automatic int phase_cnt_w(input int size);
        return $clog2(mult_cycles(size) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mxu_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : mxu_sched_if
//  Purpose  : Requester-side bus of the MXU scheduler: request/release in,
//             grant, completion and array-sequencing enables out.
//  Revision : 1.0  initial release
// ============================================================================
interface mxu_sched_if
    import mxu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PCW  = phase_cnt_w(DEF_SIZE)
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] req_i;
    logic [NREQ-1:0] release_i;
    logic [NREQ-1:0] gnt_o;
    logic [NREQ-1:0] done_o;
    logic [IW-1:0]   owner_o;
    logic            busy_o;
    logic            array_clr_o;
    logic            load_en_o;
    logic            mult_en_o;
    logic            acc_en_o;
    logic [PCW-1:0]  phase_cnt_o;

    // Requester / environment side.
    modport master (
        output req_i, release_i,
        input  gnt_o, done_o, owner_o, busy_o, array_clr_o,
               load_en_o, mult_en_o, acc_en_o, phase_cnt_o
    );

    // Scheduler side.
    modport slave (
        input  req_i, release_i,
        output gnt_o, done_o, owner_o, busy_o, array_clr_o,
               load_en_o, mult_en_o, acc_en_o, phase_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/mxu_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mxu_rr_arb
//  Purpose  : Combinational round-robin pick: first set request at or above
//             the pointer, wrapping, as a one-hot grant plus its index.
//  Revision : 1.0  initial release
// ============================================================================
module mxu_rr_arb #(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  wire logic [NREQ-1:0] req_i,
    input  wire logic [IW-1:0]   ptr_i,
    output logic      [NREQ-1:0] gnt_o,
    output logic      [IW-1:0]   idx_o
);
    logic          w_found;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    // Scan requesters in priority order starting from the pointer.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end
            w_cand = w_sum[IW-1:0];
            if (!w_found && req_i[w_cand]) begin
                w_found        = 1'b1;
                gnt_o[w_cand]  = 1'b1;
                idx_o          = w_cand;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/mxu_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mxu_sched
//  Purpose  : Shares one systolic array among NREQ requesters. Arbitrates
//             round-robin, sequences LOAD/MULT/ACC, flags completion and
//             holds the array until the owner releases it. All outputs are
//             registered from the next state.
//  Revision : 1.0  initial release
// ============================================================================
module mxu_sched
    import mxu_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int NREQ = 2
) (
    input wire logic   clk,
    input wire logic   reset,
    mxu_sched_if.slave bus
);
    localparam int IW  = $clog2(NREQ);
    localparam int PCW = phase_cnt_w(SIZE);
    localparam logic [PCW-1:0] LOAD_LAST = PCW'(load_cycles(SIZE) - 1);
    localparam logic [PCW-1:0] MULT_LAST = PCW'(mult_cycles(SIZE) - 1);
    localparam logic [PCW-1:0] PC_MAX    = '1;

    state_t          state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;
    logic            clr_q, clr_d;
    logic            load_q, load_d;
    logic            mult_q, mult_d;
    logic            acc_q, acc_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            own_req;
    logic            own_rel;
    logic [IW-1:0]   rr_next;

    mxu_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_i (bus.req_i),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign own_req = bus.req_i[owner_q];
    assign own_rel = bus.release_i[owner_q];
    // Pointer moves just past the finishing owner so it gets lowest priority.
    assign rr_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

    // Next-state, owner/pointer bookkeeping and registered-output decode.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req_i) begin
                    state_d = ST_LOAD;
                    owner_d = arb_idx;
                    gnt_d   = arb_gnt;
                end
            end
            ST_LOAD: begin
                if (!own_req)                state_d = ST_IDLE;
                else if (pc_q == LOAD_LAST)  state_d = ST_MULT;
            end
            ST_MULT: begin
                if (!own_req)                state_d = ST_IDLE;
                else if (pc_q == MULT_LAST)  state_d = ST_ACC;
            end
            ST_ACC: begin
                state_d = own_req ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (own_rel) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort and normal release share one exit path into IDLE.
        if (state_q != ST_IDLE && state_d == ST_IDLE) begin
            rr_d    = rr_next;
            owner_d = '0;
            gnt_d   = '0;
        end

        // Phase counter: restart on entry, hold 0 in IDLE, saturate otherwise.
        if (state_d != state_q || state_q == ST_IDLE) pc_d = '0;
        else if (pc_q == PC_MAX)                        pc_d = pc_q;
        else                                            pc_d = pc_q + PCW'(1);

        busy_d = (state_d != ST_IDLE);
        clr_d  = (state_d == ST_LOAD) && (state_q != ST_LOAD);
        load_d = (state_d == ST_LOAD);
        mult_d = (state_d == ST_MULT);
        acc_d  = (state_d == ST_ACC);
        done_d = ((state_d == ST_HOLD) && (state_q != ST_HOLD)) ? gnt_d : '0;
    end

    // State, counter, pointer and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            rr_q    <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
            load_q  <= 1'b0;
            mult_q  <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            clr_q   <= clr_d;
            load_q  <= load_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.done_o      = done_q;
    assign bus.owner_o     = owner_q;
    assign bus.busy_o      = busy_q;
    assign bus.array_clr_o = clr_q;
    assign bus.load_en_o   = load_q;
    assign bus.mult_en_o   = mult_q;
    assign bus.acc_en_o    = acc_q;
    assign bus.phase_cnt_o = pc_q;
endmodule
`default_nettype wire

// File: tb/tb_mxu_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mxu_sched
//  Purpose  : Directed bench for mxu_sched with a job-timeline model checked
//             every cycle plus hand-computed point expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mxu_sched;
    localparam int SIZE = 16;
    localparam int NREQ = 2;
    localparam int L    = SIZE;
    localparam int M    = 3 * SIZE - 2;
    localparam int PCW  = $clog2(M + 1);
    localparam int IW   = $clog2(NREQ);
    localparam int PMAX = (1 << PCW) - 1;
    localparam int W    = 2 * NREQ + IW + 5 + PCW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mxu_sched_if #(.NREQ(NREQ), .PCW(PCW)) bus ();

    mxu_sched #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    int t0    = 0;

    // Model: a job is just (owner, first LOAD cycle); phases follow by offset.
    bit m_busy  = 1'b0;
    int m_own   = 0;
    int m_rr    = 0;
    int m_start = 0;

    function automatic int pick(input logic [NREQ-1:0] r, input int rr);
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (rr + i) % NREQ;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] expected();
        logic [NREQ-1:0] g, d;
        logic [IW-1:0]   o;
        logic            bz, cl, ld, mu, ac;
        int              k, ph;
        g = '0; d = '0; o = '0;
        bz = 1'b0; cl = 1'b0; ld = 1'b0; mu = 1'b0; ac = 1'b0; ph = 0;
        if (m_busy) begin
            k  = cyc - m_start;
            g[m_own] = 1'b1;
            o  = IW'(m_own);
            bz = 1'b1;
            ld = (k < L);
            cl = (k == 0);
            mu = (k >= L) && (k < L + M);
            ac = (k == L + M);
            if (k == L + M + 1) d[m_own] = 1'b1;
            if (k < L)            ph = k;
            else if (k < L + M)   ph = k - L;
            else if (k == L + M)  ph = 0;
            else                  ph = (k - L - M - 1 > PMAX) ? PMAX : k - L - M - 1;
        end
        return {g, d, o, bz, cl, ld, mu, ac, PCW'(ph)};
    endfunction

    function automatic logic [W-1:0] actual();
        return {bus.gnt_o, bus.done_o, bus.owner_o, bus.busy_o, bus.array_clr_o,
                bus.load_en_o, bus.mult_en_o, bus.acc_en_o, bus.phase_cnt_o};
    endfunction

    // Model advance on each edge from the same inputs the DUT samples.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_busy <= 1'b0;
            m_rr   <= 0;
            m_own  <= 0;
        end else if (!m_busy) begin
            if (|bus.req_i) begin
                m_busy  <= 1'b1;
                m_own   <= pick(bus.req_i, m_rr);
                m_start <= cyc + 1;
            end
        end else if (((cyc - m_start) <= L + M && !bus.req_i[m_own]) ||
                     ((cyc - m_start) >  L + M &&  bus.release_i[m_own])) begin
            m_busy <= 1'b0;
            m_rr   <= (m_own + 1) % NREQ;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Whole-output comparison against the model on every cycle.
    always @(negedge clk) begin
        if (cyc >= 1) chk("model", 64'(actual()), 64'(expected()));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic at(input int n);
        while (cyc < t0 + n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_i     = '0;
        bus.release_i = '0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (|bus.done_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done @cycle %0d: no done within 300 cycles", cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int idx;
        int exp_order [4] = '{0, 1, 0, 1};

        bus.req_i     = '0;
        bus.release_i = '0;
        repeat (3) step();
        chk("reset_state", 64'(actual()), 64'd0);
        reset = 1'b0;
        step();

        // Single job timeline
        t0 = cyc;
        bus.req_i = 2'b01;
        at(1);  chk("t1_c1_gnt_load_clr", {bus.gnt_o, bus.load_en_o, bus.array_clr_o}, 4'b0111);
        at(2);  chk("t1_c2_clr_off",      {bus.load_en_o, bus.array_clr_o}, 2'b10);
        at(16); chk("t1_c16_last_load",   {bus.load_en_o, bus.mult_en_o, bus.phase_cnt_o}, {2'b10, 6'd15});
        at(17); chk("t1_c17_mult_start",  {bus.load_en_o, bus.mult_en_o, bus.phase_cnt_o}, {2'b01, 6'd0});
        at(62); chk("t1_c62_mult_last",   {bus.mult_en_o, bus.acc_en_o, bus.phase_cnt_o}, {2'b10, 6'd45});
        at(63); chk("t1_c63_acc",         {bus.mult_en_o, bus.acc_en_o, bus.done_o}, 4'b0100);
        at(64); chk("t1_c64_done",        {bus.acc_en_o, bus.done_o, bus.busy_o}, 4'b0011);
        at(65); chk("t1_c65_done_once",   {bus.done_o, bus.busy_o}, 3'b001);
        at(66); bus.req_i = 2'b00; bus.release_i = 2'b01;
        at(67); chk("t1_c67_idle",        {bus.busy_o, bus.gnt_o}, 3'b000);
        bus.release_i = 2'b00;
        step();

        // Reset mid-LOAD after the pointer has moved to 1
        t0 = cyc;
        bus.req_i = 2'b01;
        at(6);  chk("t5_load_pc5", {bus.load_en_o, bus.phase_cnt_o}, {1'b1, 6'd5});
        reset = 1'b1;
        at(7);  chk("t5_after_reset", 64'(actual()), 64'd0);
        reset = 1'b0;
        bus.req_i = 2'b11;
        at(8);  chk("t5_first_grant_req0", bus.gnt_o, 2'b01);

        // Contention with same-cycle release on each done
        for (int j = 0; j < 4; j++) begin
            wait_done(ok);
            if (ok) begin
                idx = bus.done_o[1] ? 1 : 0;
                chk("grant_order", 64'(idx), 64'(exp_order[j]));
                bus.release_i = bus.done_o;
                if (j == 3) bus.req_i = 2'b00;
                step();
                bus.release_i = 2'b00;
                chk("one_cycle_hold_idle", bus.busy_o, 1'b0);
            end
        end
        step();

        // Abort by owner 1 in MULT; pending requester 0 follows
        t0 = cyc;
        bus.req_i = 2'b10;
        at(1);  chk("t3_gnt1", bus.gnt_o, 2'b10);
        at(27); chk("t3_mult_pc10", {bus.mult_en_o, bus.phase_cnt_o}, {1'b1, 6'd10});
        bus.req_i = 2'b01;
        at(28); chk("t3_aborted", {bus.busy_o, bus.mult_en_o, bus.done_o}, 4'b0000);
        at(29); chk("t3_req0_next", {bus.gnt_o, bus.load_en_o}, 3'b011);
        wait_done(ok);
        chk("t3_done0", bus.done_o, 2'b01);
        bus.release_i = 2'b01;
        bus.req_i     = 2'b00;
        step();
        bus.release_i = 2'b00;

        // Owner stalls release while the other requester waits
        do_reset();
        bus.req_i = 2'b11;
        wait_done(ok);
        chk("t4_done0", bus.done_o, 2'b01);
        for (int j = 0; j < 20; j++) begin
            step();
            chk("t4_hold_stall",
                {bus.gnt_o, bus.done_o, bus.load_en_o, bus.mult_en_o, bus.acc_en_o, bus.busy_o},
                8'b01_00_0001);
        end
        bus.release_i = 2'b01;
        bus.req_i     = 2'b10;
        step();
        bus.release_i = 2'b00;
        chk("t4_idle", bus.busy_o, 1'b0);
        step();
        chk("t4_gnt1", bus.gnt_o, 2'b10);
        wait_done(ok);
        chk("t4_done1", bus.done_o, 2'b10);
        bus.release_i = 2'b10;
        bus.req_i     = 2'b00;
        step();
        bus.release_i = 2'b00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mxu_sched.md
Name: mxu_sched

Overview:
- Scheduler and sequencer for the systolic matrix array.
- Shares the single array between NREQ requesters using round-robin arbitration.
- For each granted job, drives the load, multiply and accumulate enables for fixed phase lengths derived from SIZE.
- Signals completion to the owner, then holds the array until the owner releases it after reading results.

Parameters:
SIZE, 16, array dimension (SIZE x SIZE PEs)
NREQ, 2, number of requesters; must be >= 2
LOAD_CYCLES, SIZE, cycles load_en is held
MULT_CYCLES, 3*SIZE-2, cycles mult_en is held (systolic fill + compute + drain)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
req  in  NREQ  per-requester job request, level; must stay high until done
release  in  NREQ  per-requester release of the array, sampled only in HOLD
gnt  out  NREQ  one-hot owner indication, held from LOAD through HOLD
done  out  NREQ  one-cycle pulse to owner on first HOLD cycle
owner  out  $clog2(NREQ)  index of current owner, valid while busy
busy  out  1  high in any state other than IDLE
array_clr  out  1  one-cycle pulse on first LOAD cycle, clears PE accumulators
load_en  out  1  high for the whole LOAD phase
mult_en  out  1  high for the whole MULT phase
acc_en  out  1  high for the single ACC cycle
phase_cnt  out  $clog2(MULT_CYCLES+1)  cycle index within current phase, 0 on entry

Behaviour:
- Reset: state IDLE; gnt, done, owner, busy, array_clr, load_en, mult_en, acc_en, phase_cnt all 0; rr pointer 0. Reset overrides everything, including mid-job; no done is issued.
- All outputs are registered and decoded from state (Moore).
- States: IDLE, LOAD, MULT, ACC, HOLD.
- IDLE: if any req bit is set, select the first set bit searching upward from rr pointer with wrap; latch owner; go to LOAD next cycle. Otherwise stay.
- LOAD: load_en=1; array_clr=1 only when phase_cnt==0. Go to MULT after LOAD_CYCLES cycles (phase_cnt reaches LOAD_CYCLES-1).
- MULT: mult_en=1 for MULT_CYCLES cycles, then go to ACC.
- ACC: acc_en=1 for one cycle, then go to HOLD.
- HOLD: done[owner]=1 on the first HOLD cycle only. Exit to IDLE on the cycle after release[owner] is seen. release asserted in the same cycle as done is legal and gives a one-cycle HOLD. On exit, rr pointer = owner+1 modulo NREQ.
- Abort: if req[owner] drops in LOAD, MULT or ACC, go to IDLE next cycle. No done pulse; rr pointer advances as on a normal exit.
- req[owner] dropping in HOLD is ignored; only release frees the array.
- release bits of non-owners, and release outside HOLD, are ignored.
- Requests from non-owners during a job are not latched; they are re-evaluated in IDLE.
- Every job passes through at least one IDLE cycle.
- phase_cnt resets to 0 on every state change and saturates in HOLD.
- Latency (SIZE=16, req seen in IDLE at edge 0):
  - gnt and load_en high from cycle 1.
  - MULT covers cycles 17–62.
  - ACC is cycle 63.
  - done pulses at cycle 64.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NREQ-1,0.

Decomposition:
- mxu_pkg holds:
  - the state enum typedef;
  - the localparam functions for LOAD_CYCLES and MULT_CYCLES from SIZE;
  - the phase_cnt width.
- One sub-module, mxu_rr_arb: combinational round-robin pick from req and pointer, returning a one-hot grant and an index.
- FSM, counter and pointer register live in mxu_sched.

Test Plan:
- Single job, SIZE=16: req[0]=1 from cycle 0, release[0] at cycle 66 -> load_en cycles 1–16, array_clr cycle 1 only, mult_en 17–62, acc_en 63, done[0] cycle 64 only, busy low from cycle 67.
- Contention: req=2'b11 held, release pulsed immediately on each done -> grant order 0,1,0,1; never two gnt bits high; at least one IDLE cycle between jobs.
- Abort: req[1] owner drops at MULT phase_cnt=10 -> next cycle IDLE, mult_en low, no done[1]; a pending req[0] is granted next.
- Hold stall: owner withholds release for 20 cycles while the other req is high -> gnt stays on owner, all enables low, done not repeated; the other requester is granted after release.
- Reset mid-job: assert reset during LOAD phase_cnt=5 -> next cycle all outputs 0 and rr pointer 0; after reset, req=2'b11 grants requester 0 first.
- Same-cycle release: release[0] asserted with done[0] -> HOLD lasts one cycle, then IDLE.
